mem_arbiter: RTL and testbench

- Sequences the single byte-wide RAM port of the RISC-V core.
- Arbitrates between two requesters: instruction fetch (IF) and load/store (MEM).
- Breaks each 1/2/4-byte access into per-byte RAM cycles and assembles or extends the read data.
- Generates the resume pulse that releases the decode-stage read-after-load stall.

---
 rtl/mem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Sequences the single byte-wide RAM port shared by instruction fetch (IF)
// and load/store (MEM). Each 1/2/4-byte access is split into per-byte RAM
// cycles. Read bytes are reassembled little-endian and sign/zero extended for
// loads. A resume pulse releases the decode-stage read-after-load stall.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   if_req_i        IF 4-byte read request, held until if_done_o
//   if_addr_i       instruction byte address
//   if_flush_i      abort any in-flight or pending IF access
//   if_done_o       one-cycle pulse, if_inst_o valid
//   if_inst_o       assembled instruction word (held until next IF completion)
//   mem_req_i       MEM request, held until mem_done_o
//   mem_we_i        1 = store, 0 = load
//   mem_funct3_i    access size / extension (B, H, W, BU, HU)
//   mem_addr_i      MEM byte address
//   mem_wdata_i     store data, low byte written first
//   mem_done_o      one-cycle pulse, MEM access complete
//   mem_rdata_o     extended load result (held until next load completion)
//   stall_resume_o  mem_done_o qualified with "was a load"
//   ram_addr_o      RAM byte address (0 when the port is idle)
//   ram_we_o        RAM write enable
//   ram_wdata_o     RAM write byte
//   ram_rdata_i     RAM read byte, valid the cycle after its address

module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic              stall_resume_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  logic              grant_mem;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata;
  logic [31:0]       rd_buf;
  logic [2:0]        cnt;
  logic [2:0]        n_bytes;

  logic [2:0]        cnt_next;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        next_wbyte;
  logic [31:0]       assembled;
  logic              is_write;
  logic              write_finish;
  logic              read_finish;

  // Number of RAM byte cycles for a request; IF always fetches a full word.
  function automatic logic [2:0] byte_count(input logic is_mem, input logic [2:0] f3);
    logic [2:0] n;
    n = 3'd4;
    if (is_mem) begin
      case (f3)
        3'b000, 3'b100: n = 3'd1;
        3'b001, 3'b101: n = 3'd2;
        default:        n = 3'd4;
      endcase
    end
    return n;
  endfunction

  // Sign or zero extension of the assembled load bytes.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{w[7]}}, w[7:0]};
      3'b001:  r = {{16{w[15]}}, w[15:0]};
      3'b100:  r = {24'b0, w[7:0]};
      3'b101:  r = {16'b0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // cnt holds k-1 during BUSY cycle k. On reads, the byte on ram_rdata_i
  // in cycle k belongs to the address issued in cycle k-1, i.e. byte cnt-1.
  always_comb begin
    cnt_next     = cnt + 3'd1;
    byte_idx     = cnt[1:0] - 2'd1;
    next_addr    = base + ADDR_W'(cnt_next);
    next_wbyte   = wdata[{cnt_next[1:0], 3'b000} +: 8];
    is_write     = grant_mem & we;
    write_finish = is_write && (cnt_next == n_bytes);
    read_finish  = !is_write && (cnt == n_bytes);
    // The final byte is merged combinationally so the result can be
    // registered on the same edge that enters DONE.
    assembled    = rd_buf;
    assembled[{byte_idx, 3'b000} +: 8] = ram_rdata_i;
  end

  // Single FSM: arbitration, byte sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant_mem      <= 1'b0;
      we             <= 1'b0;
      funct3         <= 3'b0;
      base           <= '0;
      wdata          <= 32'b0;
      rd_buf         <= 32'b0;
      cnt            <= 3'd0;
      n_bytes        <= 3'd0;
      if_done_o      <= 1'b0;
      if_inst_o      <= 32'b0;
      mem_done_o     <= 1'b0;
      mem_rdata_o    <= 32'b0;
      stall_resume_o <= 1'b0;
      ram_addr_o     <= '0;
      ram_we_o       <= 1'b0;
      ram_wdata_o    <= 8'b0;
    end else begin
      if_done_o      <= 1'b0;
      mem_done_o     <= 1'b0;
      stall_resume_o <= 1'b0;

      case (state)
        IDLE: begin
          if (mem_req_i) begin
            state       <= BUSY;
            grant_mem   <= 1'b1;
            we          <= mem_we_i;
            funct3      <= mem_funct3_i;
            base        <= mem_addr_i;
            wdata       <= mem_wdata_i;
            rd_buf      <= 32'b0;
            cnt         <= 3'd0;
            n_bytes     <= byte_count(1'b1, mem_funct3_i);
            ram_addr_o  <= mem_addr_i;
            ram_we_o    <= mem_we_i;
            ram_wdata_o <= mem_we_i ? mem_wdata_i[7:0] : 8'b0;
          end else if (if_req_i && !if_flush_i) begin
            state       <= BUSY;
            grant_mem   <= 1'b0;
            we          <= 1'b0;
            funct3      <= 3'b010;
            base        <= if_addr_i;
            wdata       <= 32'b0;
            rd_buf      <= 32'b0;
            cnt         <= 3'd0;
            n_bytes     <= byte_count(1'b0, 3'b010);
            ram_addr_o  <= if_addr_i;
            ram_we_o    <= 1'b0;
            ram_wdata_o <= 8'b0;
          end
        end

        BUSY: begin
          if (!grant_mem && if_flush_i) begin
            // Jump taken: drop the fetch, leave if_inst_o untouched.
            state       <= IDLE;
            ram_addr_o  <= '0;
            ram_we_o    <= 1'b0;
            ram_wdata_o <= 8'b0;
          end else if (is_write) begin
            if (write_finish) begin
              state       <= DONE;
              mem_done_o  <= 1'b1;
              ram_addr_o  <= '0;
              ram_we_o    <= 1'b0;
              ram_wdata_o <= 8'b0;
            end else begin
              cnt         <= cnt_next;
              ram_addr_o  <= next_addr;
              ram_wdata_o <= next_wbyte;
            end
          end else begin
            if (cnt != 3'd0) begin
              rd_buf[{byte_idx, 3'b000} +: 8] <= ram_rdata_i;
            end
            if (read_finish) begin
              state <= DONE;
              if (grant_mem) begin
                mem_rdata_o    <= extend_load(funct3, assembled);
                mem_done_o     <= 1'b1;
                stall_resume_o <= 1'b1;
              end else begin
                if_inst_o <= assembled;
                if_done_o <= 1'b1;
              end
            end else begin
              cnt <= cnt_next;
              // The last read cycle only collects data; the port goes idle.
              ram_addr_o <= (cnt_next < n_bytes) ? next_addr : '0;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. A byte-wide synchronous RAM model answers
// the DUT's RAM port (byte i holds i[7:0] at start, with 0x20 = 0x80 and
// 0x21 = 0xFF). Each step drives inputs just after a rising edge and checks
// hand-computed values for that cycle.

module tb_mem_arbiter;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              mem_req;
  logic              mem_we;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic              stall_resume;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  logic              ram_init;
  logic [7:0]        ram [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_i       (if_req),
    .if_addr_i      (if_addr),
    .if_flush_i     (if_flush),
    .if_done_o      (if_done),
    .if_inst_o      (if_inst),
    .mem_req_i      (mem_req),
    .mem_we_i       (mem_we),
    .mem_funct3_i   (mem_funct3),
    .mem_addr_i     (mem_addr),
    .mem_wdata_i    (mem_wdata),
    .mem_done_o     (mem_done),
    .mem_rdata_o    (mem_rdata),
    .stall_resume_o (stall_resume),
    .ram_addr_o     (ram_addr),
    .ram_we_o       (ram_we),
    .ram_wdata_o    (ram_wdata),
    .ram_rdata_i    (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'(i);
      ram[32] <= 8'h80;
      ram[33] <= 8'hFF;
      ram_rdata <= 8'h00;
    end else begin
      if (ram_we) ram[ram_addr[9:0]] <= ram_wdata;
      ram_rdata <= ram[ram_addr[9:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  // Load of n bytes; done expected in cycle n+2 after the accept edge.
  task automatic mem_read(input logic [2:0] f3, input logic [31:0] addr, input int n,
                          input logic [31:0] expected, input string tag);
    mem_req = 1'b1; mem_we = 1'b0; mem_funct3 = f3; mem_addr = addr; mem_wdata = 32'h0;
    for (int k = 1; k <= n + 2; k++) begin
      tick();
      if (k <= n) begin
        check_output({tag, "_addr"}, ram_addr, addr + 32'(k - 1));
        check_output({tag, "_we"}, {31'b0, ram_we}, 32'h0);
      end
      if (k < n + 2) begin
        check_output({tag, "_early_done"}, {31'b0, mem_done}, 32'h0);
      end else begin
        check_output({tag, "_done"}, {31'b0, mem_done}, 32'h1);
        check_output({tag, "_resume"}, {31'b0, stall_resume}, 32'h1);
        check_output({tag, "_rdata"}, mem_rdata, expected);
      end
    end
    mem_req = 1'b0;
    tick();
    check_output({tag, "_idle_done"}, {31'b0, mem_done}, 32'h0);
    check_output({tag, "_idle_addr"}, ram_addr, 32'h0);
  endtask

  // Store of n bytes; done expected in cycle n+1 after the accept edge.
  task automatic mem_write(input logic [2:0] f3, input logic [31:0] addr, input int n,
                           input logic [31:0] data, input string tag);
    mem_req = 1'b1; mem_we = 1'b1; mem_funct3 = f3; mem_addr = addr; mem_wdata = data;
    for (int k = 1; k <= n + 1; k++) begin
      tick();
      check_output({tag, "_resume"}, {31'b0, stall_resume}, 32'h0);
      if (k <= n) begin
        check_output({tag, "_we"}, {31'b0, ram_we}, 32'h1);
        check_output({tag, "_addr"}, ram_addr, addr + 32'(k - 1));
        check_output({tag, "_wbyte"}, {24'b0, ram_wdata}, {24'b0, 8'(data >> (8 * (k - 1)))});
        check_output({tag, "_early_done"}, {31'b0, mem_done}, 32'h0);
      end else begin
        check_output({tag, "_we_off"}, {31'b0, ram_we}, 32'h0);
        check_output({tag, "_done"}, {31'b0, mem_done}, 32'h1);
      end
    end
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    check_output({tag, "_idle_done"}, {31'b0, mem_done}, 32'h0);
  endtask

  // Instruction fetch; done expected in cycle 6 after the accept edge.
  task automatic if_read(input logic [31:0] addr, input logic [31:0] expected,
                         input string tag);
    if_req = 1'b1; if_addr = addr;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 4) begin
        check_output({tag, "_addr"}, ram_addr, addr + 32'(k - 1));
        check_output({tag, "_we"}, {31'b0, ram_we}, 32'h0);
      end
      if (k < 6) begin
        check_output({tag, "_early_done"}, {31'b0, if_done}, 32'h0);
      end else begin
        check_output({tag, "_done"}, {31'b0, if_done}, 32'h1);
        check_output({tag, "_inst"}, if_inst, expected);
        check_output({tag, "_no_mem_done"}, {31'b0, mem_done}, 32'h0);
        check_output({tag, "_no_resume"}, {31'b0, stall_resume}, 32'h0);
      end
    end
    if_req = 1'b0;
    tick();
    check_output({tag, "_idle_done"}, {31'b0, if_done}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; ram_init = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_funct3 = 3'b0; mem_addr = '0; mem_wdata = 32'h0;
    tick();
    tick();
    ram_init = 1'b0;

    // Reset state
    check_output("rst_if_done", {31'b0, if_done}, 32'h0);
    check_output("rst_mem_done", {31'b0, mem_done}, 32'h0);
    check_output("rst_resume", {31'b0, stall_resume}, 32'h0);
    check_output("rst_we", {31'b0, ram_we}, 32'h0);
    check_output("rst_addr", ram_addr, 32'h0);
    check_output("rst_wdata", {24'b0, ram_wdata}, 32'h0);
    check_output("rst_inst", if_inst, 32'h0);
    check_output("rst_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Loads of every size and extension
    mem_read(3'b010, 32'h10, 4, 32'h13121110, "ldw10");
    mem_read(3'b000, 32'h20, 1, 32'hFFFFFF80, "ldb20");
    mem_read(3'b100, 32'h20, 1, 32'h00000080, "ldbu20");
    mem_read(3'b101, 32'h20, 2, 32'h0000FF80, "ldhu20");
    mem_read(3'b001, 32'h20, 2, 32'hFFFFFF80, "ldh20");

    // Store halfword, then read back through the RAM model and the DUT
    mem_write(3'b001, 32'h40, 2, 32'hABCD1234, "sth40");
    check_output("ram40", {24'b0, ram[64]}, 32'h34);
    check_output("ram41", {24'b0, ram[65]}, 32'h12);
    check_output("ram42", {24'b0, ram[66]}, 32'h42);
    mem_read(3'b010, 32'h40, 4, 32'h43421234, "ldw40");

    // Misaligned word crossing the top of the address space
    mem_read(3'b010, 32'hFFFFFFFE, 4, 32'h0100FFFE, "ldwrap");

    // IF and MEM request together: MEM first, IF after one idle cycle
    if_req = 1'b1; if_addr = 32'h80;
    mem_req = 1'b1; mem_we = 1'b0; mem_funct3 = 3'b000; mem_addr = 32'h30;
    tick();
    check_output("arb_c1_addr", ram_addr, 32'h30);
    check_output("arb_c1_ifdone", {31'b0, if_done}, 32'h0);
    tick();
    check_output("arb_c2_done", {31'b0, mem_done}, 32'h0);
    tick();
    check_output("arb_c3_done", {31'b0, mem_done}, 32'h1);
    check_output("arb_c3_rdata", mem_rdata, 32'h00000030);
    check_output("arb_c3_ifdone", {31'b0, if_done}, 32'h0);
    mem_req = 1'b0;
    tick();
    check_output("arb_c4_addr", ram_addr, 32'h0);
    check_output("arb_c4_done", {31'b0, mem_done}, 32'h0);
    if_read(32'h80, 32'h83828180, "if80");

    // Flush in cycle 3 of a fetch; redirected fetch follows
    if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b0;
    tick();
    check_output("fl_c1_addr", ram_addr, 32'h100);
    tick();
    check_output("fl_c2_addr", ram_addr, 32'h101);
    tick();
    check_output("fl_c3_addr", ram_addr, 32'h102);
    if_flush = 1'b1; if_addr = 32'h200;
    tick();
    check_output("fl_c4_addr", ram_addr, 32'h0);
    check_output("fl_c4_we", {31'b0, ram_we}, 32'h0);
    check_output("fl_c4_ifdone", {31'b0, if_done}, 32'h0);
    check_output("fl_c4_inst", if_inst, 32'h83828180);
    if_flush = 1'b0;
    if_read(32'h200, 32'h03020100, "if200");

    // Reset in cycle 2 of a store word
    mem_req = 1'b1; mem_we = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h50;
    mem_wdata = 32'hDEADBEEF;
    tick();
    check_output("rs_c1_we", {31'b0, ram_we}, 32'h1);
    check_output("rs_c1_wbyte", {24'b0, ram_wdata}, 32'hEF);
    tick();
    check_output("rs_c2_addr", ram_addr, 32'h51);
    rst = 1'b1;
    tick();
    check_output("rs_we", {31'b0, ram_we}, 32'h0);
    check_output("rs_addr", ram_addr, 32'h0);
    check_output("rs_wdata", {24'b0, ram_wdata}, 32'h0);
    check_output("rs_mem_done", {31'b0, mem_done}, 32'h0);
    check_output("rs_if_done", {31'b0, if_done}, 32'h0);
    check_output("rs_resume", {31'b0, stall_resume}, 32'h0);
    check_output("rs_inst", if_inst, 32'h0);
    check_output("rs_rdata", mem_rdata, 32'h0);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    tick();
    check_output("rs_after_done", {31'b0, mem_done}, 32'h0);
    check_output("rs_after_we", {31'b0, ram_we}, 32'h0);
    mem_read(3'b000, 32'h50, 1, 32'hFFFFFFEF, "ldb50");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
